// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of a slow word-wide memory.
// Tags/valid live in flops for a same-cycle hit decision; data words sit in a synchronous-read array.
module dcache_wt #(
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned UNC_BIT    = 31
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_req,
  input  logic [31:0] I_addr,
  input  logic        I_we,
  input  logic [3:0]  I_mask,
  input  logic [31:0] I_data,
  input  logic        I_flush,
  output logic [31:0] O_data,
  output logic        O_stall,
  output logic        O_mem_req,
  output logic        O_mem_we,
  output logic [31:0] O_mem_addr,
  output logic [3:0]  O_mem_mask,
  output logic [31:0] O_mem_data,
  input  logic        I_mem_ack,
  input  logic [31:0] I_mem_data
);

  localparam int unsigned OFFW  = $clog2(LINE_WORDS);
  localparam int unsigned OFFS  = (OFFW == 0) ? 1 : OFFW;
  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned AW    = INDEX_BITS + OFFW;
  localparam int unsigned WORDS = 1 << AW;
  localparam int unsigned TAGW  = 30 - AW;

  typedef enum logic [2:0] {
    IDLE,
    REFILL,
    WRITE,
    UNC_RD,
    RESP,
    FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [TAGW-1:0]       tags [LINES];
  logic [LINES-1:0]      valid_q;
  logic [31:0]           ram [WORDS];

  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [31:0]           mem_addr_q;
  logic [3:0]            mem_mask_q;
  logic [31:0]           mem_data_q;
  logic [31:0]           data_q;
  logic [OFFS-1:0]       beat_q;
  logic [INDEX_BITS-1:0] flush_cnt_q;
  logic                  flush_done_q;
  logic [29:0]           lat_word;
  logic [3:0]            lat_mask;
  logic [31:0]           lat_data;
  logic                  stall;

  logic [INDEX_BITS-1:0] in_idx;
  logic [TAGW-1:0]       in_tag;
  logic                  in_unc;
  logic                  in_hit;
  logic [INDEX_BITS-1:0] mem_idx;
  logic [TAGW-1:0]       mem_tag;
  logic                  mem_hit;
  logic                  ack;
  logic                  last_beat;
  logic                  load_hit;
  logic [29:0]           refill_word;
  logic                  unused_addr;

  assign in_idx  = I_addr[AW+1:2+OFFW];
  assign in_tag  = I_addr[31:AW+2];
  assign in_unc  = I_addr[UNC_BIT];
  assign in_hit  = !in_unc && valid_q[in_idx] && (tags[in_idx] == in_tag);

  assign mem_idx = mem_addr_q[AW+1:2+OFFW];
  assign mem_tag = mem_addr_q[31:AW+2];
  assign mem_hit = !mem_addr_q[UNC_BIT] && valid_q[mem_idx] && (tags[mem_idx] == mem_tag);

  assign ack         = mem_req_q && I_mem_ack;
  assign last_beat   = (beat_q == OFFS'(LINE_WORDS - 1));
  assign refill_word = (lat_word & ~30'(LINE_WORDS - 1)) | 30'(beat_q);
  assign load_hit    = (state_q == IDLE) && I_req && !I_we && !I_flush && in_hit;
  assign unused_addr = ^I_addr[1:0];

  // A flush held by the core after FLUSH finishes is acknowledged in IDLE
  // (stall low) instead of starting a second sweep.
  always_comb begin
    state_d = state_q;
    stall   = 1'b1;
    case (state_q)
      IDLE: begin
        stall = 1'b0;
        if (I_flush) begin
          if (!flush_done_q) begin
            stall   = 1'b1;
            state_d = FLUSH;
          end
        end else if (I_req) begin
          if (I_we) begin
            stall   = 1'b1;
            state_d = WRITE;
          end else if (in_unc) begin
            stall   = 1'b1;
            state_d = UNC_RD;
          end else if (!in_hit) begin
            stall   = 1'b1;
            state_d = REFILL;
          end
        end
      end
      REFILL: if (ack && last_beat) state_d = IDLE;
      WRITE:  if (ack) state_d = RESP;
      UNC_RD: if (ack) state_d = RESP;
      RESP: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
      FLUSH:  if (flush_cnt_q == '1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (I_rst) stall = 1'b1;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_mask_q   <= '0;
      mem_data_q   <= '0;
      data_q       <= '0;
      beat_q       <= '0;
      flush_cnt_q  <= '0;
      flush_done_q <= 1'b0;
      lat_word     <= '0;
      lat_mask     <= '0;
      lat_data     <= '0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= (state_q == FLUSH) && (state_d == IDLE);
      if (load_hit) data_q <= ram[I_addr[AW+1:2]];
      case (state_q)
        IDLE: begin
          beat_q      <= '0;
          flush_cnt_q <= '0;
          if (I_req) begin
            lat_word <= I_addr[31:2];
            lat_mask <= I_mask;
            lat_data <= I_data;
          end
        end
        REFILL: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {refill_word, 2'b00};
            mem_mask_q <= 4'hF;
          end else if (I_mem_ack) begin
            mem_req_q <= 1'b0;
            beat_q    <= beat_q + 1'b1;
            if (last_beat) valid_q[mem_idx] <= 1'b1;
          end
        end
        WRITE: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= {lat_word, 2'b00};
            mem_mask_q <= lat_mask;
            mem_data_q <= lat_data;
          end else if (I_mem_ack) begin
            mem_req_q <= 1'b0;
          end
        end
        UNC_RD: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {lat_word, 2'b00};
            mem_mask_q <= 4'hF;
          end else if (I_mem_ack) begin
            mem_req_q <= 1'b0;
            data_q    <= I_mem_data;
          end
        end
        FLUSH: begin
          valid_q[flush_cnt_q] <= 1'b0;
          flush_cnt_q          <= flush_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Refill beats and write-through hits update the data array; tags are set with the last beat.
  always_ff @(posedge I_clk) begin
    if (!I_rst && ack) begin
      if (state_q == REFILL) begin
        ram[mem_addr_q[AW+1:2]] <= I_mem_data;
        if (last_beat) tags[mem_idx] <= mem_tag;
      end
      if (state_q == WRITE && mem_hit) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (mem_mask_q[b]) ram[mem_addr_q[AW+1:2]][8*b +: 8] <= mem_data_q[8*b +: 8];
        end
      end
    end
  end

  assign O_data     = data_q;
  assign O_stall    = stall;
  assign O_mem_req  = mem_req_q;
  assign O_mem_we   = mem_we_q;
  assign O_mem_addr = mem_addr_q;
  assign O_mem_mask = mem_mask_q;
  assign O_mem_data = mem_data_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Scoreboard bench for dcache_wt: expected memory traffic and load data are queued at issue
// and checked when the memory sees a request or the core access completes.
module tb_dcache_wt;

  localparam int unsigned IB    = 8;
  localparam int unsigned LW    = 4;
  localparam int unsigned OFF   = 2;
  localparam int unsigned LINES = 1 << IB;
  localparam int          LAT   = 2;

  typedef struct {
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  tx_t         exp_tx[$];
  logic [31:0] exp_ld[$];
  logic [31:0] refmem [logic [31:0]];
  logic [LINES-1:0] bvalid;
  logic [31:0]      btag [LINES];
  logic [31:0]      last_data;

  always #5 clk = ~clk;

  dcache_wt #(.INDEX_BITS(IB), .LINE_WORDS(LW), .UNC_BIT(31)) dut (
    .I_clk(clk), .I_rst(rst), .I_req(req), .I_addr(addr), .I_we(we), .I_mask(mask),
    .I_data(wdata), .I_flush(flush), .O_data(rdata), .O_stall(stall),
    .O_mem_req(mem_req), .O_mem_we(mem_we), .O_mem_addr(mem_addr), .O_mem_mask(mem_mask),
    .O_mem_data(mem_wdata), .I_mem_ack(mem_ack), .I_mem_data(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (refmem.exists(a)) return refmem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Backing memory: acks LAT cycles after the request rises, checks each request in order.
  initial begin
    int cnt;
    tx_t t;
    mem_ack = 1'b0;
    mem_rdata = '0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (rst || !mem_req) cnt = 0;
      else begin
        cnt++;
        if (cnt == LAT) begin
          cnt = 0;
          mem_ack = 1'b1;
          if (exp_tx.size() == 0) begin
            check("mem_unexpected", mem_addr, 32'hFFFF_FFFF);
          end else begin
            t = exp_tx.pop_front();
            check("mem_addr", mem_addr, t.addr);
            check("mem_we", {31'b0, mem_we}, {31'b0, t.we});
            check("mem_mask", {28'b0, mem_mask}, {28'b0, t.mask});
            if (t.we) check("mem_wdata", mem_wdata, t.data);
          end
          mem_rdata = mem_rd({mem_addr[31:2], 2'b00});
        end
      end
    end
  end

  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d);
    logic [31:0] wa;
    int idx, cnt, exp_stall;
    logic [31:0] tg;
    logic hit;
    tx_t t;
    wa  = {a[31:2], 2'b00};
    idx = int'((wa >> (2 + OFF)) % LINES);
    tg  = wa >> (2 + OFF + IB);
    hit = !wa[31] && bvalid[idx] && (btag[idx] == tg);
    if (w) begin
      t = '{we: 1'b1, mask: m, addr: wa, data: d};
      exp_tx.push_back(t);
      refmem[wa] = merge(mem_rd(wa), d, m);
      exp_stall = 2 + LAT;
    end else if (wa[31]) begin
      t = '{we: 1'b0, mask: 4'hF, addr: wa, data: 32'h0};
      exp_tx.push_back(t);
      exp_ld.push_back(mem_rd(wa));
      exp_stall = 2 + LAT;
    end else if (hit) begin
      exp_ld.push_back(mem_rd(wa));
      exp_stall = 0;
    end else begin
      for (int b = 0; b < int'(LW); b++) begin
        t = '{we: 1'b0, mask: 4'hF, addr: (wa & ~32'(LW*4-1)) | 32'(b*4), data: 32'h0};
        exp_tx.push_back(t);
      end
      bvalid[idx] = 1'b1;
      btag[idx]   = tg;
      exp_ld.push_back(mem_rd(wa));
      exp_stall = 1 + int'(LW) * (1 + LAT);
    end
    @(posedge clk);
    #1;
    req = 1'b1; we = w; addr = a; mask = m; wdata = d;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      cnt++;
      if (cnt > 1000) begin
        check("access_timeout", 32'(cnt), 32'(exp_stall));
        break;
      end
    end
    @(posedge clk);
    #1;
    req = 1'b0;
    check("stall_cycles", 32'(cnt), 32'(exp_stall));
    if (w) check("store_keeps_data", rdata, last_data);
    else begin
      last_data = exp_ld.pop_front();
      check("load_data", rdata, last_data);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; mask = '0; wdata = '0; flush = 1'b0;
    bvalid = '0;
    last_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'b0, stall}, 32'd1);
    check("rst_data", rdata, 32'd0);
    check("rst_memreq", {31'b0, mem_req}, 32'd0);
    check("rst_memaddr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_stall", {31'b0, stall}, 32'd0);

    access(1'b0, 32'h100, 4'h0, 32'h0);
    access(1'b0, 32'h104, 4'h0, 32'h0);
    access(1'b1, 32'h104, 4'b0101, 32'hAABBCCDD);
    access(1'b0, 32'h104, 4'h0, 32'h0);
    check("merged_bytes", rdata, (32'h8B5E74A1 & 32'h0) | merge({16'h0104, 16'hFEFB}, 32'hAABBCCDD, 4'b0101));

    access(1'b1, 32'h8000_0000, 4'hF, 32'h1234_5678);
    access(1'b0, 32'h8000_0000, 4'h0, 32'h0);
    access(1'b0, 32'h8000_0000, 4'h0, 32'h0);

    access(1'b0, 32'h100, 4'h0, 32'h0);
    access(1'b0, 32'h100 + ((LW * 4) << IB), 4'h0, 32'h0);
    access(1'b0, 32'h100, 4'h0, 32'h0);
    for (int i = 0; i < 6; i++) access(1'b0, 32'h200 + 32'(4 * i), 4'h0, 32'h0);

    @(posedge clk);
    #1;
    flush = 1'b1;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      cnt++;
      if (cnt > 2000) break;
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_len_ok", {31'b0, (cnt >= int'(LINES)) && (cnt <= int'(LINES) + 2)}, 32'd1);
    bvalid = '0;
    access(1'b0, 32'h100, 4'h0, 32'h0);
    access(1'b1, 32'h30C, 4'hF, 32'hCAFE_F00D);
    access(1'b0, 32'h30C, 4'h0, 32'h0);

    // Reset while the second refill beat is outstanding.
    for (int b = 0; b < int'(LW); b++)
      exp_tx.push_back('{we: 1'b0, mask: 4'hF, addr: 32'h400 + 32'(b * 4), data: 32'h0});
    @(posedge clk);
    #1;
    req = 1'b1; we = 1'b0; addr = 32'h400;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h404) break;
      cnt++;
      if (cnt > 200) begin
        check("beat1_timeout", mem_addr, 32'h404);
        break;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    check("midrst_stall", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_tx.delete();
    bvalid = '0;
    @(negedge clk);
    check("midrst_memreq", {31'b0, mem_req}, 32'd0);
    check("midrst_idle", {31'b0, stall}, 32'd0);
    access(1'b0, 32'h400, 4'h0, 32'h0);
    access(1'b0, 32'h100, 4'h0, 32'h0);

    repeat (4) @(posedge clk);
    check("tx_left", 32'(exp_tx.size()), 32'd0);
    check("ld_left", 32'(exp_ld.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
